// File: rtl/mmm_serial_core_if.sv
// mmm_serial_core_if: operand/result bus for the bit-serial Montgomery multiplier.
//   master : exponentiation control side (drives ena/clear/start/operands)
//   slave  : multiplier core (drives result/busy/done[/err])
// Optional MMM_OPCHECK_EN adds the err flag to the bus.
interface mmm_serial_core_if #(parameter int WIDTH = 8);
  logic             ena;
  logic             clear;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
`ifdef MMM_OPCHECK_EN
  logic             err;

  modport master (output ena, clear, start, a_in, b_in, m_in,
                  input  result, busy, done, err);
  modport slave  (input  ena, clear, start, a_in, b_in, m_in,
                  output result, busy, done, err);
`else
  modport master (output ena, clear, start, a_in, b_in, m_in,
                  input  result, busy, done);
  modport slave  (input  ena, clear, start, a_in, b_in, m_in,
                  output result, busy, done);
`endif
endinterface

// File: rtl/mmm_serial_core.sv
// mmm_serial_core: radix-2 bit-serial Montgomery multiplier,
//   result = A * B * 2^-WIDTH mod M.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mmm_serial_core_if.slave (ena, clear, start, a_in, b_in, m_in ->
//          result, busy, done[, err])
// Macro MMM_OPCHECK_EN: registers an operand sanity flag (err) on start and
//   short-circuits the iteration when operands are illegal.
// Timing: start sampled at edge k, done visible after edge k+WIDTH+2; a new
//   start may be sampled in the same cycle done is high (WIDTH+3 per op).
module mmm_serial_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mmm_serial_core_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, CORRECT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_r, m_r, result_r;
  logic [WIDTH+1:0] acc;
  logic [CW-1:0]    cnt;
  logic             busy_r, done_r;

  // Iteration datapath: add B when the scanned A bit is set, add M to make
  // the sum even, then halve.
  logic             ai, q;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ge_m;

  always_comb begin
    ai   = a_sh[0];
    q    = acc[0] ^ (ai & b_r[0]);
    sum  = acc + (ai ? {2'b00, b_r} : '0) + (q ? {2'b00, m_r} : '0);
    ge_m = (acc >= {2'b00, m_r});
    // Only the low WIDTH bits survive the final truncation.
    diff = acc[WIDTH-1:0] - m_r;
  end

`ifdef MMM_OPCHECK_EN
  logic err_r, op_bad;
  always_comb
    op_bad = ~bus.m_in[0] | (bus.m_in < WIDTH'(2)) |
             (bus.a_in >= bus.m_in) | (bus.b_in >= bus.m_in);
  assign bus.err = err_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_r      <= '0;
      m_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef MMM_OPCHECK_EN
      err_r    <= 1'b0;
`endif
    end else if (bus.ena) begin
      done_r <= 1'b0;
      if (bus.clear) begin
        state  <= IDLE;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              a_sh   <= bus.a_in;
              b_r    <= bus.b_in;
              m_r    <= bus.m_in;
              acc    <= '0;
              cnt    <= '0;
              busy_r <= 1'b1;
`ifdef MMM_OPCHECK_EN
              err_r  <= op_bad;
              // Bad operands bypass the iterations; CORRECT forces result=0
              // so done still lands two edges after start.
              state  <= op_bad ? CORRECT : ITER;
`else
              state  <= ITER;
`endif
            end else begin
              // busy stays up through the done cycle, drops afterwards.
              busy_r <= 1'b0;
            end
          end
          ITER: begin
            acc  <= sum >> 1;
            a_sh <= a_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= CORRECT;
          end
          CORRECT: begin
`ifdef MMM_OPCHECK_EN
            if (err_r)     result_r <= '0;
            else
`endif
            if (ge_m)      result_r <= diff;
            else           result_r <= acc[WIDTH-1:0];
            state <= DONE;
          end
          DONE: begin
            done_r <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
endmodule

// File: tb/tb_mmm_serial_core.sv
// tb_mmm_serial_core: directed-vector bench for mmm_serial_core (WIDTH=8).
module tb_mmm_serial_core;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mmm_serial_core_if #(.WIDTH(WIDTH)) bus ();

  mmm_serial_core #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampled edge; returns just after that edge.
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.m_in  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, dn;
    bus.ena = 1'b1; bus.clear = 1'b0; bus.start = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.m_in = '0;
    #12;
    check("rst_result", bus.result, 0);
    check("rst_busy",   bus.busy,   0);
    check("rst_done",   bus.done,   0);
    rst = 1'b0;
    tick();

    // basic op and latency
    go(5, 7, 13);
    check("busy_after_start", bus.busy, 1);
    wait_done(n);
    check("lat_5_7_13", n, 10);
    check("res_5_7_13", bus.result, 1);
    tick();
    check("done_one_cycle", bus.done, 0);

    go(1, 1, 13);    wait_done(n); check("res_1_1_13", bus.result, 3);
    go(12, 12, 13);  wait_done(n); check("res_12_12_13", bus.result, 3);
    go(0, 99, 251);  wait_done(n); check("res_0_99_251", bus.result, 0);

    // back-to-back start in the done cycle, operands scrambled afterwards
    go(200, 150, 251);
    bus.a_in = 8'hff; bus.b_in = 8'h00; bus.m_in = 8'h02;
    wait_done(n);
    check("lat_b2b", n, 10);
    check("res_200_150_251", bus.result, 227);
    tick();

    // clear mid-op
    go(5, 7, 13);
    repeat (3) tick();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    check("clear_busy", bus.busy, 0);
    check("clear_result_kept", bus.result, 227);
    dn = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (bus.done) dn++; end
    check("clear_no_done", dn, 0);
    go(12, 12, 13); wait_done(n);
    check("after_clear_lat", n, 10);
    check("after_clear_res", bus.result, 3);
    tick();

    // ena low for 3 cycles mid-op
    go(5, 7, 13);
    repeat (3) tick();
    bus.ena = 1'b0;
    repeat (3) tick();
    check("ena_hold_busy", bus.busy, 1);
    bus.ena = 1'b1;
    wait_done(n);
    check("ena_lat", n + 6, 13);
    check("ena_res", bus.result, 1);
    // done stretched while ena is low
    bus.ena = 1'b0;
    repeat (2) tick();
    check("done_stretch", bus.done, 1);
    bus.ena = 1'b1;
    tick();
    check("done_release", bus.done, 0);
    tick();

    // start and clear together in IDLE: nothing starts
    bus.clear = 1'b1;
    go(5, 7, 13);
    bus.clear = 1'b0;
    check("start_clear_idle", bus.busy, 0);

    // start while busy is ignored
    go(1, 1, 13);
    repeat (2) tick();
    go(200, 150, 251);
    wait_done(n);
    check("busy_start_lat", n + 3, 10);
    check("busy_start_res", bus.result, 3);
    tick();

    // async reset mid-op
    go(5, 7, 13);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_result", bus.result, 0);
    check("rst_mid_busy",   bus.busy,   0);
    check("rst_mid_done",   bus.done,   0);
    #3;
    rst = 1'b0;
    tick();

`ifdef MMM_OPCHECK_EN
    go(5, 7, 12); wait_done(n);
    check("err_even_m", bus.err, 1);
    check("err_lat", n, 2);
    check("err_result", bus.result, 0);
    tick();
    go(13, 1, 13); wait_done(n);
    check("err_a_eq_m", bus.err, 1);
    tick();
    go(5, 7, 13); wait_done(n);
    check("err_clear", bus.err, 0);
    check("err_ok_res", bus.result, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
